uart_peripheral: RTL and testbench
==================================

Name: uart_peripheral

Overview:
- Memory-mapped UART on the CPU data bus, in the MEM stage beside DataMem.
- Decoded when the ALU address is at or above 256; rdata feeds the MEM-stage read-data mux.
- Serialises bytes written by sw and deserialises bytes for lw, with 16x oversampling on RX.
- Raises irq toward the Control IRQ input.

Parameters:
CLK_HZ, 50000000, core clock frequency in Hz.
BAUD, 9600, line rate in bit/s.
OSR, 16, oversampling ticks per bit. DIV = CLK_HZ/(BAUD*OSR), truncated, minimum 1.

Ports:
clk  in  1  core clock (divided clock used by the pipeline)
reset  in  1  synchronous, active-high
rd  in  1  bus read strobe (MemRead_MEM)
wr  in  1  bus write strobe (MemWrite_MEM)
addr  in  32  byte address (outZ_MEM)
wdata  in  32  write data (Databus2_MEM)
rdata  out  32  read data, combinational
irq  out  1  interrupt request, level
UART_RX  in  1  serial input, asynchronous
UART_TX  out  1  serial output, idle high

Behaviour:
Register map (word addresses; other addresses are ignored, rdata=0):
- 0x40000018 TXD: write loads wdata[7:0] and starts a frame. Read returns {24'b0, last TX byte}.
- 0x4000001C RXD: read returns {24'b0, rx_data}. A read clears rx_valid at the clock edge.
- 0x40000020 CON: bit0 tx_ie (RW), bit1 rx_ie (RW), bit2 rx_valid (RO), bit3 tx_done (sticky), bit4 tx_busy (RO), bit5 overrun (sticky), bit6 frame_err (sticky). Bits 31:7 read 0.
  - A CON write updates bits 1:0 only.
  - A CON read returns the current value; bits 3, 5 and 6 clear at that edge.
- rdata = 0 whenever rd=0.

Reset values:
- UART_TX=1, irq=0.
- CON=0, tx_byte=0, rx_data=0.
- Both FSMs return to IDLE and the baud divider clears.
- Reset mid-frame aborts the frame; UART_TX is high on the next cycle.

Tick and irq:
- tick: one-cycle pulse every DIV clocks, free-running.
- irq = (tx_ie & tx_done) | (rx_ie & rx_valid), registered (1-cycle delay).

TX FSM (IDLE, START, DATA, STOP):
- TXD write in IDLE latches the byte, sets tx_busy and enters START. Tick count restarts at 0.
- START drives 0 for OSR ticks.
- DATA drives LSB first, 8 bits, OSR ticks each.
- STOP drives 1 for OSR ticks.
- On the last STOP tick: go to IDLE, clear tx_busy, set tx_done.
- A TXD write while tx_busy=1 is ignored, including in the cycle STOP completes.
- A TXD write the cycle after completion is accepted.

RX path:
- UART_RX passes through a 2-flop synchroniser, reset to 1.

RX FSM (IDLE, START, DATA, STOP):
- IDLE: on synchronised 1->0 go to START, tick count 0.
- START: at tick OSR/2, still low → DATA; high → IDLE (glitch, no flags).
- DATA: sample at the middle tick of each bit, LSB first, 8 bits.
- STOP: sample at mid-bit.
  - High: load rx_data, set rx_valid. If rx_valid was already 1, also set overrun; the new byte overwrites the old.
  - Low: discard the byte, set frame_err, and wait for the line to go high before IDLE.
- Same-cycle RXD read and byte arrival: rdata returns the old byte, and rx_valid ends at 1 (set wins over clear).

Other rules:
- Simultaneous rd and wr to the same address: the write takes effect and the read side-effect still applies.
- Latency:
  - TXD write to UART_TX falling edge: 1 cycle.
  - Stop-bit mid-sample to rx_valid: 1 cycle.
  - rx_valid to irq: 1 cycle.

Decomposition:
- Shared package uart_pkg: address constants (UART_TXD_ADDR, UART_RXD_ADDR, UART_CON_ADDR), CON bit indices, the 2-bit FSM state encodings, and OSR.
- One sub-module, uart_baud_tick (CLK_HZ, BAUD, OSR → tick pulse), instantiated once and shared by TX and RX.

Test Plan:
All scenarios use CLK_HZ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clocks.
1. Reset, then write TXD=0x5A with tx_ie=1.
   → UART_TX waveform 0,0,1,0,1,1,0,1,0,1 (start, LSB-first data, stop), each level 160 cycles.
   → CON bit4=1 during the frame; bit3=1 and irq=1 after it.
   → CON read returns 0x09, then bit3=0.
2. Write TXD=0x11, then TXD=0x22 at cycle 50.
   → Only 0x11 is transmitted and a TXD read returns 0x11.
   → A third write 1 cycle after tx_busy falls is transmitted.
3. Drive 0xA3 onto UART_RX at nominal rate with rx_ie=1.
   → rx_valid=1 and irq=1; an RXD read returns 0x000000A3.
   → rx_valid=0 and irq=0 the cycle after the read.
4. Send 0x01 then 0x02 without reading.
   → RXD returns 0x02 and CON bit5=1.
   → A CON read clears bit5; a second CON read shows bit5=0.
5. Pull UART_RX low for 40 cycles only.
   → No rx_valid, no flags.
   → A frame with stop bit 0 sets bit6 and leaves rx_valid=0.
6. Assert reset at cycle 300 of a TX frame.
   → UART_TX=1 next cycle, CON=0.
   → A new TXD write transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the memory-mapped UART.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int unsigned CON_TX_IE     = 32'd0;
  localparam int unsigned CON_RX_IE     = 32'd1;
  localparam int unsigned CON_RX_VALID  = 32'd2;
  localparam int unsigned CON_TX_DONE   = 32'd3;
  localparam int unsigned CON_TX_BUSY   = 32'd4;
  localparam int unsigned CON_OVERRUN   = 32'd5;
  localparam int unsigned CON_FRAME_ERR = 32'd6;

  localparam int unsigned UART_OSR = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clocks per oversampling tick, never below one.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned osr);
    int unsigned d;
    d = clk_hz / (baud * osr);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick: a one-cycle pulse every DIV clocks.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned CLK_HZ = 32'd50000000,
  parameter int unsigned BAUD   = 32'd9600,
  parameter int unsigned OSR    = UART_OSR
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OSR);
  localparam int unsigned CW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Divider counter with registered tick pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CW'(DIV - 32'd1)) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 framing, 16x oversampled RX.
module uart_peripheral import uart_pkg::*; #(
  parameter int unsigned CLK_HZ = 32'd50000000,
  parameter int unsigned BAUD   = 32'd9600,
  parameter int unsigned OSR    = UART_OSR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned    TW     = $clog2(OSR);
  localparam logic [TW-1:0]  T_LAST = TW'(OSR - 32'd1);
  localparam logic [TW-1:0]  T_MID  = TW'(OSR / 32'd2 - 32'd1);

  logic        tick_s;
  logic        tx_wr_s, con_wr_s, rxd_rd_s, con_rd_s;
  logic [31:0] con_s;
  logic        unused_s;

  logic        tx_ie_r, rx_ie_r, irq_r;
  logic        tx_busy_r, tx_done_r, tx_line_r;
  logic        rx_valid_r, overrun_r, frame_err_r;
  logic [7:0]  tx_byte_r, tx_shift_r, rx_data_r, rx_shift_r;
  logic [2:0]  tx_bit_r, rx_bit_r;
  logic [TW-1:0] tx_cnt_r, rx_cnt_r;
  uart_state_e tx_state_r, rx_state_r;
  logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_hold_r;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign tx_wr_s  = wr & (addr == UART_TXD_ADDR);
  assign con_wr_s = wr & (addr == UART_CON_ADDR);
  assign rxd_rd_s = rd & (addr == UART_RXD_ADDR);
  assign con_rd_s = rd & (addr == UART_CON_ADDR);
  assign unused_s = ^wdata[31:8];

  assign con_s = {25'd0, frame_err_r, overrun_r, tx_busy_r, tx_done_r,
                  rx_valid_r, rx_ie_r, tx_ie_r};

  // Bus read mux; reads have no data without rd
  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (addr)
        UART_TXD_ADDR: rdata = {24'd0, tx_byte_r};
        UART_RXD_ADDR: rdata = {24'd0, rx_data_r};
        UART_CON_ADDR: rdata = con_s;
        default:       rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // Interrupt enables and the registered interrupt line
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ie_r <= 1'b0;
      rx_ie_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      if (con_wr_s) begin
        tx_ie_r <= wdata[CON_TX_IE];
        rx_ie_r <= wdata[CON_RX_IE];
      end
      irq_r <= (tx_ie_r & tx_done_r) | (rx_ie_r & rx_valid_r);
    end
  end

  // TX FSM; a completion on the same edge as a CON read keeps tx_done set
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_byte_r  <= 8'd0;
      tx_line_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      if (con_rd_s) tx_done_r <= 1'b0;
      case (tx_state_r)
        ST_IDLE: if (tx_wr_s) begin
          tx_byte_r  <= wdata[7:0];
          tx_shift_r <= wdata[7:0];
          tx_busy_r  <= 1'b1;
          tx_cnt_r   <= '0;
          tx_line_r  <= 1'b0;
          tx_state_r <= ST_START;
        end
        ST_START: if (tick_s) begin
          if (tx_cnt_r == T_LAST) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= tx_shift_r[0];
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + TW'(1);
          end
        end
        ST_DATA: if (tick_s) begin
          if (tx_cnt_r == T_LAST) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == 3'd7) begin
              tx_line_r  <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_line_r  <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + TW'(1);
          end
        end
        ST_STOP: if (tick_s) begin
          if (tx_cnt_r == T_LAST) begin
            tx_cnt_r   <= '0;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b1;
            tx_state_r <= ST_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + TW'(1);
          end
        end
        default: tx_state_r <= ST_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= UART_RX;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // RX FSM; flag sets are written after the read-clears so set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r  <= ST_IDLE;
      rx_cnt_r    <= '0;
      rx_bit_r    <= 3'd0;
      rx_shift_r  <= 8'd0;
      rx_data_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      rx_hold_r   <= 1'b0;
    end else begin
      if (rxd_rd_s) rx_valid_r <= 1'b0;
      if (con_rd_s) begin
        overrun_r   <= 1'b0;
        frame_err_r <= 1'b0;
      end
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r  <= '0;
          rx_hold_r <= 1'b0;
          if (rx_prev_r & ~rx_sync_r) rx_state_r <= ST_START;
        end
        ST_START: if (tick_s) begin
          if (rx_cnt_r == T_MID) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + TW'(1);
          end
        end
        ST_DATA: if (tick_s) begin
          if (rx_cnt_r == T_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + TW'(1);
          end
        end
        ST_STOP: begin
          if (rx_hold_r) begin
            if (rx_sync_r) rx_state_r <= ST_IDLE;
          end else if (tick_s) begin
            if (rx_cnt_r == T_LAST) begin
              rx_cnt_r <= '0;
              if (rx_sync_r) begin
                rx_data_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
                if (rx_valid_r) overrun_r <= 1'b1;
                rx_state_r <= ST_IDLE;
              end else begin
                frame_err_r <= 1'b1;
                rx_hold_r   <= 1'b1;
              end
            end else begin
              rx_cnt_r <= rx_cnt_r + TW'(1);
            end
          end
        end
        default: rx_state_r <= ST_IDLE;
      endcase
    end
  end

  assign irq     = irq_r;
  assign UART_TX = tx_line_r;

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral at DIV=10 (160 clocks per bit).
module tb_uart_peripheral;

  localparam int unsigned CLK_HZ  = 32'd1600000;
  localparam int unsigned BAUD    = 32'd10000;
  localparam int          BIT_CYC = 160;
  localparam logic [31:0] A_TXD   = 32'h4000_0018;
  localparam logic [31:0] A_RXD   = 32'h4000_001C;
  localparam logic [31:0] A_CON   = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  logic        UART_RX = 1'b1;
  logic        UART_TX;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] d;
  logic [7:0]  b;
  logic [7:0]  q[$];
  int          found;
  int          n;

  uart_peripheral #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(32'd16)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .UART_RX (UART_RX),
    .UART_TX (UART_TX)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic do_reset();
    rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; UART_RX = 1'b1;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    addr = a; wdata = v; wr = 1'b1;
    cyc(1);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    #1;
    v = rdata;
    cyc(1);
    rd = 1'b0;
  endtask

  // Samples the line at mid-bit for ten bits and compares with an 8N1 frame of v.
  task automatic tx_frame_check(input logic [7:0] v, input int first, input string name);
    logic [9:0] got;
    logic [9:0] want;
    want = {1'b1, v, 1'b0};
    cyc(first);
    got[0] = UART_TX;
    for (int k = 1; k < 10; k++) begin
      cyc(BIT_CYC);
      got[k] = UART_TX;
    end
    check(name, {22'd0, got}, {22'd0, want});
  endtask

  task automatic rx_send(input logic [7:0] v, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, v, 1'b0};
    UART_RX = 1'b1;
    cyc(20);
    for (int k = 0; k < 10; k++) begin
      UART_RX = f[k];
      cyc(BIT_CYC);
    end
    UART_RX = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, A_CON, 32'd0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, A_TXD, 32'd0, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, A_RXD, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, A_CON, 32'hFFFF_FFFF, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, A_CON, 32'd0, 32'h0000_0003};
    vecs[5]  = '{1'b0, 1'b0, A_CON, 32'd0, 32'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'h4000_0024, 32'd0, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0100, 32'd0, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, A_CON, 32'h0000_0001, 32'h0000_0003};
    vecs[9]  = '{1'b1, 1'b0, A_CON, 32'd0, 32'h0000_0001};
    vecs[10] = '{1'b0, 1'b1, A_CON, 32'd0, 32'd0};
    vecs[11] = '{1'b1, 1'b0, A_CON, 32'd0, 32'd0};

    do_reset();
    check("reset_tx_line", 32'(UART_TX), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 12; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
      cyc(1);
      rd = 1'b0; wr = 1'b0;
    end

    // Scenario 1: transmit 0x5A with tx_ie
    do_reset();
    bus_write(A_CON, 32'h1);
    bus_write(A_TXD, 32'h5A);
    check("t1_start_latency", 32'(UART_TX), 32'd0);
    bus_read(A_CON, d);
    check("t1_con_busy", d, 32'h11);
    tx_frame_check(8'h5A, 79, "t1_frame");
    cyc(90);
    check("t1_irq", 32'(irq), 32'd1);
    bus_read(A_CON, d);
    check("t1_con_done", d, 32'h09);
    bus_read(A_CON, d);
    check("t1_con_cleared", d, 32'h01);
    check("t1_irq_cleared", 32'(irq), 32'd0);

    // Scenario 2: writes while busy are dropped, write right after completion is taken
    do_reset();
    bus_write(A_TXD, 32'h11);
    cyc(48);
    bus_write(A_TXD, 32'h22);
    bus_read(A_TXD, d);
    check("t2_txd_kept", d, 32'h11);
    tx_frame_check(8'h11, 29, "t2_frame");
    found = 0;
    for (int i = 0; i < 300; i++) begin
      addr = A_CON; rd = 1'b1;
      #1;
      if (rdata[4] == 1'b0) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    rd = 1'b0;
    check("t2_busy_falls", 32'(found), 32'd1);
    bus_write(A_TXD, 32'h33);
    check("t2_third_accepted", 32'(UART_TX), 32'd0);
    tx_frame_check(8'h33, 80, "t2_third_frame");
    cyc(78);
    addr = A_TXD; wdata = 32'h44; wr = 1'b1;
    cyc(1);
    wr = 1'b0;
    bus_read(A_CON, d);
    check("t2_write_at_stop_ignored", d, 32'h08);
    bus_read(A_TXD, d);
    check("t2_txd_after", d, 32'h33);

    // Scenario 3: receive 0xA3 with rx_ie
    do_reset();
    bus_write(A_CON, 32'h2);
    rx_send(8'hA3, 1'b1);
    cyc(5);
    check("t3_irq", 32'(irq), 32'd1);
    bus_read(A_CON, d);
    check("t3_con_valid", d, 32'h06);
    bus_read(A_RXD, d);
    check("t3_rxd", d, 32'hA3);
    bus_read(A_CON, d);
    check("t3_valid_cleared", d, 32'h02);
    check("t3_irq_cleared", 32'(irq), 32'd0);

    // Scenario 4: overrun
    do_reset();
    rx_send(8'h01, 1'b1);
    rx_send(8'h02, 1'b1);
    cyc(5);
    bus_read(A_RXD, d);
    check("t4_rxd_newest", d, 32'h02);
    bus_read(A_CON, d);
    check("t4_overrun", d, 32'h20);
    bus_read(A_CON, d);
    check("t4_overrun_cleared", d, 32'h00);

    // Scenario 5: glitch rejection and framing error
    do_reset();
    UART_RX = 1'b0;
    cyc(40);
    UART_RX = 1'b1;
    cyc(300);
    bus_read(A_CON, d);
    check("t5_glitch_no_flags", d, 32'h00);
    rx_send(8'h55, 1'b0);
    cyc(5);
    bus_read(A_CON, d);
    check("t5_frame_err", d, 32'h40);
    rx_send(8'h3C, 1'b1);
    cyc(5);
    bus_read(A_RXD, d);
    check("t5_recover", d, 32'h3C);

    // Scenario 6: reset mid-frame
    do_reset();
    bus_write(A_TXD, 32'h77);
    cyc(298);
    reset = 1'b1;
    cyc(1);
    check("t6_tx_high", 32'(UART_TX), 32'd1);
    reset = 1'b0;
    bus_read(A_CON, d);
    check("t6_con_zero", d, 32'h00);
    bus_read(A_TXD, d);
    check("t6_txd_zero", d, 32'h00);
    bus_write(A_TXD, 32'hC4);
    tx_frame_check(8'hC4, 80, "t6_frame");
    cyc(90);

    // Randomised TX bytes against the frame model
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(A_TXD, {24'd0, b});
      tx_frame_check(b, 80, "rand_tx_frame");
      cyc(90);
      bus_read(A_TXD, d);
      check("rand_txd", d, {24'd0, b});
    end

    // Randomised RX bursts against a queue model of unread bytes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 3);
      q.delete();
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        rx_send(b, 1'b1);
        q.push_back(b);
      end
      cyc(5);
      bus_read(A_CON, d);
      check("rand_rx_con", d, ((q.size() > 1) ? 32'h20 : 32'h00) | 32'h04);
      bus_read(A_RXD, d);
      check("rand_rx_data", d, {24'd0, q[$]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
